led_display_driver: RTL and testbench

LED_DISPLAY_DRIVER -- requirements
Module: led_display_driver

---
 rtl/led_display_driver_pkg.sv | 20 ++
 rtl/led_display_driver_hex_to_7seg.sv | 13 +
 rtl/led_display_driver.sv | 84 ++++++++
 tb/tb_led_display_driver.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/led_display_driver_pkg.sv
// Shared constants for the multiplexed 7-segment display driver:
// digit count, blank/idle output values and the hex-to-segment table.
package led_display_driver_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [5:0] EN_NONE   = 6'h3F;

  // Active-low a..g in bits 0..6, dp (bit 7) held off; entry 0 in the low byte.
  localparam logic [16*8-1:0] HEX_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_seg(input logic [3:0] hex);
    return HEX_SEG_TABLE[{hex, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/led_display_driver_hex_to_7seg.sv
// Combinational hex digit to active-low 7-segment pattern (dp off).
module hex_to_7seg
  import led_display_driver_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = hex_seg(hex_i);
  end

endmodule

// File: rtl/led_display_driver.sv
// Six-digit time-multiplexed 7-segment driver: each digit owns a slot of
// DIGIT_CYCLES clocks; segments and digit select are registered together.
module led_display_driver
  import led_display_driver_pkg::*;
#(
  parameter int CLK_RATE_HZ  = 100_000_000,
  parameter int SCAN_RATE_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] data,
  input  logic [5:0]  digit_enable_mask,
  output logic [7:0]  display_led_segments,
  output logic [5:0]  display_led_enable_mask
);

  localparam int RATIO        = CLK_RATE_HZ / SCAN_RATE_HZ;
  localparam int DIGIT_CYCLES = (RATIO > 1) ? RATIO : 1;
  localparam int CNT_W        = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [7:0]       seg_q, seg_d;
  logic [5:0]       en_q, en_d;

  logic [3:0]       cur_hex;
  logic [7:0]       cur_seg;

  always_comb begin
    cur_hex = data[3:0];
    case (digit_q)
      3'd0:    cur_hex = data[3:0];
      3'd1:    cur_hex = data[7:4];
      3'd2:    cur_hex = data[11:8];
      3'd3:    cur_hex = data[15:12];
      3'd4:    cur_hex = data[19:16];
      3'd5:    cur_hex = data[23:20];
      default: cur_hex = data[3:0];
    endcase
  end

  hex_to_7seg u_hex_to_7seg (
    .hex_i (cur_hex),
    .seg_o (cur_seg)
  );

  // Outputs are computed from the slot index before it advances, so the
  // select and its pattern always change on the same edge.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    digit_d = digit_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = (digit_q == DIGIT_LAST) ? 3'd0 : digit_q + 3'd1;
    end
    if (digit_enable_mask[digit_q]) begin
      seg_d = cur_seg;
      en_d  = EN_NONE & ~(6'd1 << digit_q);
    end else begin
      seg_d = SEG_BLANK;
      en_d  = EN_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      digit_q <= 3'd0;
      seg_q   <= SEG_BLANK;
      en_q    <= EN_NONE;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
    end
  end

  assign display_led_segments    = seg_q;
  assign display_led_enable_mask = en_q;

endmodule

// File: tb/tb_led_display_driver.sv
// Bench for led_display_driver at 10 cycles per digit: directed scan
// scenarios plus randomized data/mask/reset against a slot-time model.
module tb_led_display_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] data;
  logic [5:0]  digit_enable_mask;
  logic [7:0]  display_led_segments;
  logic [5:0]  display_led_enable_mask;

  int vectors = 0;
  int errors  = 0;
  int n_edges = 0;   // non-reset edges since the last reset edge
  logic [7:0] exp_seg;
  logic [5:0] exp_en;

  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  led_display_driver #(
    .CLK_RATE_HZ  (10000),
    .SCAN_RATE_HZ (1000)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .data                    (data),
    .digit_enable_mask       (digit_enable_mask),
    .display_led_segments    (display_led_segments),
    .display_led_enable_mask (display_led_enable_mask)
  );

  // At most one digit select may be active in any cycle.
  always @(negedge clk) begin
    if (!$isunknown(display_led_enable_mask)) begin
      vectors++;
      if ($countones(~display_led_enable_mask) > 1) begin
        errors++;
        $display("FAIL one_hot_enable: enable=%h has more than one low bit", display_led_enable_mask);
      end
    end
  end

  // One clock: model the edge from the inputs presented, then compare at negedge.
  task automatic step(input string name);
    int slot;
    @(posedge clk);
    if (reset) begin
      exp_seg = 8'hFF;
      exp_en  = 6'h3F;
      n_edges = 0;
    end else begin
      slot = (n_edges / 10) % 6;
      if (digit_enable_mask[slot]) begin
        exp_seg = hex_tbl[data[slot*4 +: 4]];
        exp_en  = 6'h3F & ~(6'd1 << slot);
      end else begin
        exp_seg = 8'hFF;
        exp_en  = 6'h3F;
      end
      n_edges++;
    end
    @(negedge clk);
    vectors++;
    if (display_led_segments !== exp_seg || display_led_enable_mask !== exp_en) begin
      errors++;
      $display("FAIL %s: got seg=%h en=%h, expected seg=%h en=%h (edge %0d)",
               name, display_led_segments, display_led_enable_mask, exp_seg, exp_en, n_edges);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data = 24'h123456;
    digit_enable_mask = 6'h3F;
    step("reset_hold_0");
    step("reset_hold_1");
    reset = 1'b0;
  endtask

  task automatic test_scan_pattern();
    logic [5:0] en_ref  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    logic [7:0] seg_ref [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    data = 24'h123456;
    digit_enable_mask = 6'h3F;
    for (int i = 0; i < 120; i++) begin
      step("scan_123456");
      if (i % 10 == 5) begin
        vectors++;
        if (display_led_enable_mask !== en_ref[(i/10)%6] || display_led_segments !== seg_ref[(i/10)%6]) begin
          errors++;
          $display("FAIL scan_table slot %0d: got en=%h seg=%h, expected en=%h seg=%h", (i/10)%6,
                   display_led_enable_mask, display_led_segments, en_ref[(i/10)%6], seg_ref[(i/10)%6]);
        end
      end
    end
  endtask

  task automatic test_masked();
    data = 24'h123456;
    digit_enable_mask = 6'b101010;
    for (int i = 0; i < 60; i++) step("masked_101010");
  endtask

  task automatic test_hex_letters();
    data = 24'hFEDCBA;
    digit_enable_mask = 6'h3F;
    for (int i = 0; i < 60; i++) step("hex_FEDCBA");
  endtask

  task automatic test_reset_mid_slot();
    int guard = 0;
    data = 24'h123456;
    digit_enable_mask = 6'h3F;
    while (!(((n_edges / 10) % 6) == 3 && (n_edges % 10) == 4) && guard < 100) begin
      step("pre_mid_reset");
      guard++;
    end
    vectors++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL reach_slot3: got edge %0d, expected mid slot 3 within 100 cycles", n_edges);
    end
    reset = 1'b1;
    step("mid_slot_reset");
    reset = 1'b0;
    for (int i = 0; i < 22; i++) step("restart_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) data = $urandom();
      if ($urandom_range(0, 7) == 0) digit_enable_mask = 6'($urandom_range(0, 63));
      reset = ($urandom_range(0, 199) == 0);
      step("random");
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_pattern();
    test_masked();
    test_hex_letters();
    test_reset_mid_slot();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
